// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler in front of a UART core's register-write port.
// It issues one control-register write after reset, then forwards requester
// bytes to the TX data register one at a time. Each byte is paced by the core's
// TX-done pulse. A grant is held until the last byte of a packet, and a
// watchdog releases a transfer that stalls.
module uart_tx_sched #(
    parameter int          NREQ        = 4,
    parameter logic [15:0] BAUD_DIV    = 16'd868,
    parameter logic [3:0]  CTRL_ADDR   = 4'h0,
    parameter logic [3:0]  TXDATA_ADDR = 4'h4,
    parameter logic [19:0] TIMEOUT     = 20'd200000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [8*NREQ-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic              we_o,
    output logic [3:0]        addr_o,
    output logic [31:0]       wdata_o,
    input  logic              tx_done_i,
    output logic [NREQ-1:0]   grant_o,
    output logic              busy_o,
    output logic              cfg_done_o,
    output logic              err_o
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [2:0] {S_CFG, S_IDLE, S_LOAD, S_WAIT, S_HOLD} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic            last_q, last_d;
    logic [19:0]     cnt_q, cnt_d;
    logic            cfg_done_q, cfg_done_d;
    logic            err_q, err_d;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   gidx_inc;
    logic            expired;
    logic [7:0]      gdata;

    assign gidx_inc = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
    assign expired  = (cnt_q == TIMEOUT - 20'd1);
    assign gdata    = req_data_i[{gidx_q, 3'b000} +: 8];

    // Arbiter: first valid requester scanning upward from the rr pointer, with wrap.
    // The loop runs from the farthest slot down so the nearest one wins.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (req_valid_i[idx]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(idx);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_CFG;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_q       <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            cfg_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_q       <= rr_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            cfg_done_q <= cfg_done_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic: arbitration, packet lock, TX-done pacing and the watchdog.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_d       = rr_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        cfg_done_d = cfg_done_q;
        err_d      = 1'b0;
        case (state_q)
            S_CFG: begin
                cfg_done_d = 1'b1;
                state_d    = S_IDLE;
            end
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    gidx_d  = pick_idx;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                last_d  = req_last_i[gidx_q];
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 20'd1;
                // TX-done takes priority over a watchdog expiry in the same cycle.
                if (tx_done_i) begin
                    if (last_q) begin
                        grant_d = '0;
                        rr_d    = gidx_inc;
                        state_d = S_IDLE;
                    end else if (req_valid_i[gidx_q]) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_HOLD;
                    end
                end else if (expired) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    rr_d    = gidx_inc;
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q + 20'd1;
                if (req_valid_i[gidx_q]) begin
                    state_d = S_LOAD;
                end else if (expired) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    rr_d    = gidx_inc;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_CFG;
        endcase
    end

    // Register-write port: the control write in CFG, the data write in LOAD, zeros otherwise.
    // The CFG strobe is qualified with rst_ni so every output reads 0 while reset is held.
    always_comb begin
        we_o    = 1'b0;
        addr_o  = 4'h0;
        wdata_o = 32'h0;
        case (state_q)
            S_CFG: begin
                if (rst_ni) begin
                    we_o    = 1'b1;
                    addr_o  = CTRL_ADDR;
                    wdata_o = {BAUD_DIV, 15'b0, 1'b1};
                end
            end
            S_LOAD: begin
                we_o    = 1'b1;
                addr_o  = TXDATA_ADDR;
                wdata_o = {24'b0, gdata};
            end
            default: ;
        endcase
    end

    // Ready is a single-cycle pulse to the owner while its byte is written.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready_o[gi] = (state_q == S_LOAD) && grant_q[gi];
    end

    assign grant_o    = grant_q;
    assign busy_o     = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_HOLD);
    assign cfg_done_o = cfg_done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched. It covers the start-up control write, a
// single byte, round-robin order, packet lock with a HOLD gap, the watchdog,
// TX-done outside WAIT, and reset during a transfer.
module tb_uart_tx_sched;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic              we;
    logic [3:0]        addr;
    logic [31:0]       wdata;
    logic              tx_done = 1'b0;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              cfg_done;
    logic              err;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_sched #(
        .NREQ(NREQ),
        .BAUD_DIV(16'd868),
        .CTRL_ADDR(4'h0),
        .TXDATA_ADDR(4'h4),
        .TIMEOUT(20'd16)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_valid_i(req_valid),
        .req_data_i(req_data),
        .req_last_i(req_last),
        .req_ready_o(req_ready),
        .we_o(we),
        .addr_o(addr),
        .wdata_o(wdata),
        .tx_done_i(tx_done),
        .grant_o(grant),
        .busy_o(busy),
        .cfg_done_o(cfg_done),
        .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance into LOAD and check the data write for owner g.
    task automatic load_check(input string tag, input logic [NREQ-1:0] g, input logic [7:0] d);
        step();
        chk({tag, "_ready"}, 32'(req_ready), 32'(g));
        chk({tag, "_grant"}, 32'(grant), 32'(g));
        chk({tag, "_we"}, 32'(we), 32'd1);
        chk({tag, "_addr"}, 32'(addr), 32'h4);
        chk({tag, "_wdata"}, wdata, {24'b0, d});
    endtask

    // LOAD -> WAIT, then one TX-done pulse.
    task automatic finish_byte(input string tag);
        step();
        chk({tag, "_wait_we"}, 32'(we), 32'd0);
        chk({tag, "_wait_ready"}, 32'(req_ready), 32'd0);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_cfg_done", 32'(cfg_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Control write immediately after release
        rst_n = 1'b1;
        #1;
        chk("cfg_we", 32'(we), 32'd1);
        chk("cfg_addr", 32'(addr), 32'h0);
        chk("cfg_wdata", wdata, 32'h0364_0001);
        chk("cfg_done_early", 32'(cfg_done), 32'd0);
        step();
        chk("cfg_done", 32'(cfg_done), 32'd1);
        chk("cfg_we_off", 32'(we), 32'd0);

        // Round-robin from rr=0 over requesters 0,1,3
        req_data[0*8 +: 8] = 8'hA0;
        req_data[1*8 +: 8] = 8'hA1;
        req_data[3*8 +: 8] = 8'hA3;
        req_last  = 4'b1111;
        req_valid = 4'b1011;
        load_check("rr0", 4'b0001, 8'hA0);
        finish_byte("rr0");
        chk("rr0_release", 32'(grant), 32'd0);
        load_check("rr1", 4'b0010, 8'hA1);
        finish_byte("rr1");
        load_check("rr3", 4'b1000, 8'hA3);
        finish_byte("rr3");
        load_check("rr0b", 4'b0001, 8'hA0);
        finish_byte("rr0b");
        req_valid = '0;
        req_last  = '0;

        // Single byte from requester 2 (rr now 1)
        req_data[2*8 +: 8] = 8'h41;
        req_last  = 4'b0100;
        req_valid = 4'b0100;
        load_check("sb", 4'b0100, 8'h41);
        step();
        req_valid = '0;
        chk("sb_wait_grant", 32'(grant), 32'h4);
        chk("sb_wait_busy", 32'(busy), 32'd1);
        chk("sb_wait_we", 32'(we), 32'd0);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("sb_release", 32'(grant), 32'd0);
        chk("sb_idle_busy", 32'(busy), 32'd0);

        // TX-done in IDLE is ignored
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("idle_done_grant", 32'(grant), 32'd0);
        chk("idle_done_busy", 32'(busy), 32'd0);

        // Packet lock: requester 1 sends 3 bytes while requester 0 waits (rr now 3)
        req_last  = '0;
        req_data[1*8 +: 8] = 8'hB1;
        req_valid = 4'b0010;
        load_check("pk1", 4'b0010, 8'hB1);
        req_data[0*8 +: 8] = 8'hC0;
        req_last[0] = 1'b1;
        req_valid = 4'b0011;
        step();
        req_data[1*8 +: 8] = 8'hB2;
        chk("pk1_wait_ready", 32'(req_ready), 32'd0);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("pk2_ready", 32'(req_ready), 32'h2);
        chk("pk2_wdata", wdata, 32'hB2);
        step();
        req_valid[1] = 1'b0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("hold_grant", 32'(grant), 32'h2);
        chk("hold_ready", 32'(req_ready), 32'd0);
        chk("hold_busy", 32'(busy), 32'd1);
        step();
        chk("hold2_ready", 32'(req_ready), 32'd0);
        chk("hold2_we", 32'(we), 32'd0);
        req_data[1*8 +: 8] = 8'hB3;
        req_last[1]  = 1'b1;
        req_valid[1] = 1'b1;
        step();
        chk("pk3_ready", 32'(req_ready), 32'h2);
        chk("pk3_wdata", wdata, 32'hB3);
        step();
        req_valid[1] = 1'b0;
        req_last[1]  = 1'b0;
        chk("pk3_wait_ready", 32'(req_ready), 32'd0);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("pk_release", 32'(grant), 32'd0);
        load_check("pk_req0", 4'b0001, 8'hC0);
        finish_byte("pk_req0");
        req_valid = '0;
        req_last  = '0;

        // Watchdog: requester 3 never gets TX-done (rr now 1)
        req_data[3*8 +: 8] = 8'hD3;
        req_valid = 4'b1000;
        load_check("to", 4'b1000, 8'hD3);
        step();
        req_valid = '0;
        req_data[2*8 +: 8] = 8'hE2;
        req_last  = 4'b0100;
        req_valid = 4'b0100;
        chk("to_err_0", 32'(err), 32'd0);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk($sformatf("to_err_%0d", i), 32'(err), 32'd0);
            chk($sformatf("to_grant_%0d", i), 32'(grant), 32'h8);
        end
        step();
        chk("to_err_16", 32'(err), 32'd1);
        chk("to_release", 32'(grant), 32'd0);
        chk("to_busy", 32'(busy), 32'd0);
        load_check("to_next", 4'b0100, 8'hE2);
        chk("to_err_pulse_end", 32'(err), 32'd0);
        step();
        req_valid = '0;
        chk("rw_wait_grant", 32'(grant), 32'h4);

        // Reset mid-WAIT
        rst_n = 1'b0;
        #1;
        chk("rw_grant", 32'(grant), 32'd0);
        chk("rw_cfg_done", 32'(cfg_done), 32'd0);
        chk("rw_we", 32'(we), 32'd0);
        chk("rw_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rw_cfg_we", 32'(we), 32'd1);
        chk("rw_cfg_addr", 32'(addr), 32'h0);
        chk("rw_cfg_wdata", wdata, 32'h0364_0001);
        chk("rw_cfg_ready", 32'(req_ready), 32'd0);
        step();
        chk("rw_cfg_done", 32'(cfg_done), 32'd1);
        chk("rw_we_off", 32'(we), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin transmit scheduler that shares one UART core's register-write port among NREQ byte-stream requesters. After reset it writes the core's control register once (baud divisor, TX enable). It then forwards requester bytes to the TX data register, one at a time, paced by the core's TX-done pulse. A grant is held for a whole packet (until `last`), and a watchdog releases a stalled transfer.

Parameters:
NREQ, 4, number of requesters (2..8)
BAUD_DIV, 16'd868, divisor written to the control register at start-up
CTRL_ADDR, 4'h0, control register address
TXDATA_ADDR, 4'h4, TX data register address
TIMEOUT, 20'd200000, max cycles to wait for tx_done_i per byte

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NREQ  per-requester byte valid
req_data_i  in  8*NREQ  byte for requester i at [8i+7:8i]
req_last_i  in  NREQ  byte is last of packet
req_ready_o  out  NREQ  byte accepted (one-hot, single-cycle)
we_o  out  1  register write strobe to UART core
addr_o  out  4  register address
wdata_o  out  32  register write data
tx_done_i  in  1  TX-done pulse from UART core (intr_tx)
grant_o  out  NREQ  one-hot current owner, 0 when none
busy_o  out  1  state != IDLE/CFG_DONE
cfg_done_o  out  1  control write issued (sticky)
err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Interface: one clock `clk_i`; reset `rst_ni` is asynchronous, active-low.
- Reset values: all outputs 0, state CFG, rr pointer 0, timeout counter 0.
- State machine: CFG, IDLE, LOAD, WAIT, HOLD.
- CFG (first cycle after reset release):
  - we_o=1, addr_o=CTRL_ADDR, wdata_o={BAUD_DIV[15:0],15'b0,1'b1}.
  - Next state IDLE; cfg_done_o=1 from the next cycle onward.
- IDLE:
  - If any req_valid_i, pick the first valid requester scanning from rr pointer upward, with wrap.
  - Register grant_o; next state LOAD.
  - Arbitration is combinational from registered state; latency from valid to write strobe is 1 cycle.
- LOAD (exactly 1 cycle):
  - we_o=1, addr_o=TXDATA_ADDR, wdata_o={24'b0, data of granted requester}, req_ready_o[g]=1.
  - Capture req_last_i[g] into last_q; clear timeout counter; next state WAIT.
- we_o is 0 in every state except CFG and LOAD. addr_o/wdata_o are 0 when we_o=0.
- WAIT: increment timeout counter each cycle.
  - On tx_done_i=1:
    - last_q=1: clear grant_o, set rr pointer to g+1 mod NREQ, go IDLE.
    - last_q=0 and req_valid_i[g]=1: go LOAD.
    - last_q=0 and req_valid_i[g]=0: go HOLD.
  - If counter reaches TIMEOUT-1 without tx_done_i: pulse err_o, clear grant_o, rr pointer = g+1, go IDLE.
  - tx_done_i and timeout in the same cycle: tx_done_i wins, no error.
- HOLD (mid-packet, granted requester not valid):
  - Keep grant_o; other requesters are ignored.
  - Go LOAD when req_valid_i[g]=1.
  - The timeout counter also runs here. On expiry: err_o pulse, release grant, go IDLE.
- tx_done_i outside WAIT is ignored.
- req_valid_i of non-granted requesters never produces ready.
- req_ready_o asserts only in LOAD.
- Requesters hold data stable while valid until ready.
- Reset mid-transfer: immediate return to reset values; CFG write is re-issued after release.
- Round-robin fairness: a requester that just completed a packet has lowest priority next arbitration.

Test Plan:
- CFG write: release reset → cycle 1: we_o=1, addr_o=0, wdata_o=0x03640001. Cycle 2: cfg_done_o=1, we_o=0.
- Single byte: req 2 sends 0x41 with last=1.
  - LOAD one cycle after valid in IDLE: we_o=1, addr_o=4, wdata_o=0x41, req_ready_o=4'b0100.
  - On tx_done_i, grant_o returns to 0 next cycle.
- Round-robin: reqs 0,1,3 all valid with last=1 and rr=0 → grant order 0,1,3,0. Each grant is preceded by tx_done_i.
- Packet lock: req 1 sends 3 bytes (last on third) while req 0 is valid.
  - req 0 gets no ready until req 1's third tx_done_i.
  - A mid-packet valid gap on req 1 holds the grant (HOLD state).
- Timeout: TIMEOUT=16, no tx_done_i after LOAD.
  - err_o pulses exactly 16 cycles after entering WAIT; grant released.
  - The next valid requester is served.
- Reset mid-WAIT: rst_ni low for 1 cycle → grant_o=0, cfg_done_o=0. After release, the CFG write recurs before any data write.
